video_slot_sched: RTL and testbench

- Sequencer for the shared SRAM video slot.
- Each Gigatron cycle is 4 CLKx4 ticks: 2 ticks go to the Gigatron, 2 to video fetch.
- The block tracks HSYNC/VSYNC from Gigatron OUT writes and generates the frame-buffer fetch address, slot strobes and pixel-load strobes.
- It sits between the ctrl-bit decoder (config), the Gigatron bus snoop (OUT writes) and the SRAM address/data muxes.

---
 rtl/video_slot_sched.sv | 197 +++++++++++++++++++
 tb/tb_video_slot_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_slot_sched.sv
// video_slot_sched: shares the SRAM between the Gigatron and video fetch.
// Each Gigatron cycle spans four CLKx4 ticks; PH 0,1 belong to the Gigatron,
// PH 2,3 to video. Sync state is recovered from OUT register writes and used
// to generate per-line fetch addresses, slot strobes and pixel-load strobes.
module video_slot_sched #(
    parameter int NPIX     = 160,
    parameter int HBP      = 11,
    parameter int NROWS    = 120,
    parameter int LINE_REP = 4
) (
    input  logic        CLKx4,
    input  logic        nRESET,
    input  logic [1:0]  PH,
    input  logic        CFG_WE,
    input  logic        CFG_VRUN,
    input  logic        CFG_HDBL,
    input  logic [7:0]  CFG_BASE,
    input  logic        OUTWR,
    input  logic [1:0]  OUTV,
    output logic        nAE,
    output logic        VRD,
    output logic        VSEL,
    output logic [15:0] VADDR,
    output logic        PIXLD,
    output logic        VACTIVE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VBLANK = 3'd1;
    localparam logic [2:0] S_HSYNC  = 3'd2;
    localparam logic [2:0] S_BP     = 3'd3;
    localparam logic [2:0] S_ACTIVE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [7:0] X_LAST   = 8'(NPIX - 1);
    localparam logic [7:0] REP_LAST = 8'(LINE_REP - 1);
    localparam logic [7:0] ROW_END  = 8'(NROWS);
    localparam logic [7:0] HBP_INIT = 8'(HBP);

    logic [2:0]  state_q, state_d;
    logic        vrun_q, vrun_d;
    logic        hdbl_q, hdbl_d;
    logic [7:0]  base_q, base_d;
    logic        hdbl_line_q, hdbl_line_d;
    logic [7:0]  base_line_q, base_line_d;
    logic [1:0]  last_sync_q, last_sync_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  rep_q, rep_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        nae_q, nae_d;
    logic        vrd_q, vrd_d;
    logic        vsel_q, vsel_d;
    logic [15:0] vaddr_q, vaddr_d;
    logic        pixld_q, pixld_d;
    logic        vactive_q, vactive_d;

    logic        vs_low, hs_fall, hs_rise, sync_chg, in_line, fetch_ph;
    logic [7:0]  row_inc, page;

    // Next-state: config first, then sync events, then line/pixel timing.
    always_comb begin
        state_d     = state_q;
        vrun_d      = vrun_q;
        hdbl_d      = hdbl_q;
        base_d      = base_q;
        hdbl_line_d = hdbl_line_q;
        base_line_d = base_line_q;
        last_sync_d = last_sync_q;
        row_d       = row_q;
        rep_d       = rep_q;
        x_d         = x_q;
        cnt_d       = cnt_q;
        row_inc     = row_q + 8'd1;
        page        = base_line_q + row_q;

        if (CFG_WE) begin
            vrun_d = CFG_VRUN;
            hdbl_d = CFG_HDBL;
            base_d = CFG_BASE;
        end
        if (OUTWR) begin
            last_sync_d = OUTV;
        end

        vs_low   = OUTWR && !OUTV[1];
        hs_fall  = OUTWR && OUTV[1] && last_sync_q[0] && !OUTV[0];
        hs_rise  = OUTWR && OUTV[1] && !last_sync_q[0] && OUTV[0];
        sync_chg = OUTWR && (OUTV != last_sync_q);
        in_line  = (state_q == S_ACTIVE) || (state_q == S_BP);

        if (!vrun_d) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            state_d = S_VBLANK;
        end else if (vs_low) begin
            state_d = S_VBLANK;
            row_d   = 8'd0;
            rep_d   = 8'd0;
        end else if (hs_fall && state_q != S_DONE) begin
            state_d = S_HSYNC;
        end else if (hs_rise && state_q == S_HSYNC) begin
            state_d = S_BP;
            cnt_d   = HBP_INIT;
        end else if (sync_chg && in_line) begin
            // Unexpected sync change mid-line: drop the line, keep row/rep.
            state_d = S_VBLANK;
        end else if (PH == 2'd3) begin
            case (state_q)
                S_BP: begin
                    if (cnt_q <= 8'd1) begin
                        state_d     = S_ACTIVE;
                        x_d         = 8'd0;
                        hdbl_line_d = hdbl_d;
                        base_line_d = base_d;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_ACTIVE: begin
                    if (x_q == X_LAST) begin
                        if (rep_q == REP_LAST) begin
                            rep_d   = 8'd0;
                            row_d   = row_inc;
                            state_d = (row_inc == ROW_END) ? S_DONE : S_HSYNC;
                        end else begin
                            rep_d   = rep_q + 8'd1;
                            state_d = S_HSYNC;
                        end
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end

        // Fetch only while ACTIVE persists into the next tick, so any exit
        // (abort, VRUN off, VSYNC) suppresses the strobe immediately.
        fetch_ph  = (PH == 2'd1) || ((PH == 2'd2) && hdbl_line_q);
        nae_d     = !((PH == 2'd3) || (PH == 2'd0));
        vrd_d     = (state_q == S_ACTIVE) && (state_d == S_ACTIVE) && fetch_ph;
        vsel_d    = vrd_d ? (PH == 2'd2) : vsel_q;
        vaddr_d   = vrd_d ? {page, x_q} : vaddr_q;
        pixld_d   = vrd_q && vrun_d;
        vactive_d = (state_d == S_ACTIVE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLKx4 or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= S_IDLE;
            vrun_q      <= 1'b0;
            hdbl_q      <= 1'b0;
            base_q      <= 8'h08;
            hdbl_line_q <= 1'b0;
            base_line_q <= 8'h08;
            last_sync_q <= 2'b11;
            row_q       <= 8'd0;
            rep_q       <= 8'd0;
            x_q         <= 8'd0;
            cnt_q       <= 8'd0;
            nae_q       <= 1'b1;
            vrd_q       <= 1'b0;
            vsel_q      <= 1'b0;
            vaddr_q     <= 16'h0000;
            pixld_q     <= 1'b0;
            vactive_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vrun_q      <= vrun_d;
            hdbl_q      <= hdbl_d;
            base_q      <= base_d;
            hdbl_line_q <= hdbl_line_d;
            base_line_q <= base_line_d;
            last_sync_q <= last_sync_d;
            row_q       <= row_d;
            rep_q       <= rep_d;
            x_q         <= x_d;
            cnt_q       <= cnt_d;
            nae_q       <= nae_d;
            vrd_q       <= vrd_d;
            vsel_q      <= vsel_d;
            vaddr_q     <= vaddr_d;
            pixld_q     <= pixld_d;
            vactive_q   <= vactive_d;
        end
    end

    assign nAE     = nae_q;
    assign VRD     = vrd_q;
    assign VSEL    = vsel_q;
    assign VADDR   = vaddr_q;
    assign PIXLD   = pixld_q;
    assign VACTIVE = vactive_q;

endmodule

// File: tb/tb_video_slot_sched.sv
// Directed testbench for video_slot_sched. NROWS is reduced to 6 so that a
// whole frame (24 scanlines) fits in a short run; line geometry is default.
module tb_video_slot_sched;

    logic        CLKx4 = 1'b0;
    logic        nRESET = 1'b1;
    logic [1:0]  PH = 2'd0;
    logic        CFG_WE = 1'b0;
    logic        CFG_VRUN = 1'b0;
    logic        CFG_HDBL = 1'b0;
    logic [7:0]  CFG_BASE = 8'h00;
    logic        OUTWR = 1'b0;
    logic [1:0]  OUTV = 2'b11;
    logic        nAE, VRD, VSEL, PIXLD, VACTIVE;
    logic [15:0] VADDR;

    int n_checks = 0;
    int n_fail   = 0;

    video_slot_sched #(.NPIX(160), .HBP(11), .NROWS(6), .LINE_REP(4)) dut (
        .CLKx4(CLKx4), .nRESET(nRESET), .PH(PH),
        .CFG_WE(CFG_WE), .CFG_VRUN(CFG_VRUN), .CFG_HDBL(CFG_HDBL), .CFG_BASE(CFG_BASE),
        .OUTWR(OUTWR), .OUTV(OUTV),
        .nAE(nAE), .VRD(VRD), .VSEL(VSEL), .VADDR(VADDR), .PIXLD(PIXLD), .VACTIVE(VACTIVE)
    );

    always #5 CLKx4 = ~CLKx4;

    // One CLKx4 tick; outputs are stable when this returns.
    task automatic step();
        @(posedge CLKx4);
        #1;
        PH    = PH + 2'd1;
        OUTWR = 1'b0;
        CFG_WE = 1'b0;
    endtask

    task automatic send_out(input logic [1:0] v);
        OUTWR = 1'b1;
        OUTV  = v;
        step();
    endtask

    task automatic set_cfg(input logic vrun, input logic hdbl, input logic [7:0] base);
        CFG_WE = 1'b1; CFG_VRUN = vrun; CFG_HDBL = hdbl; CFG_BASE = base;
        step();
    endtask

    // HSYNC low then high; the rising write always lands on a PH==3 edge.
    task automatic start_line();
        send_out(2'b10);
        step();
        step();
        for (int i = 0; i < 4 && PH != 2'd3; i++) step();
        send_out(2'b11);
    endtask

    // Observe a scanline, collecting counts and a tally of per-tick anomalies.
    task automatic capture(input logic hdbl, output int nvrd, output int npix,
                           output int first_t, output int vact, output int bad,
                           output logic [15:0] first_addr, output logic [15:0] last_addr);
        logic        prev_vrd;
        logic        exp_sel;
        logic [1:0]  exp_ph;
        logic [15:0] exp_addr;
        int          xi;
        nvrd = 0; npix = 0; first_t = -1; vact = 0; bad = 0;
        first_addr = 16'h0000; last_addr = 16'h0000;
        prev_vrd = VRD;
        for (int t = 1; t <= 700; t++) begin
            step();
            if (nAE !== !((PH == 2'd0) || (PH == 2'd1))) bad++;
            if (PIXLD !== prev_vrd) bad++;
            if (PIXLD === 1'b1) npix++;
            if (VACTIVE === 1'b1) vact++;
            if (VRD === 1'b1) begin
                if (nvrd == 0) begin
                    first_t    = t;
                    first_addr = VADDR;
                end
                xi       = hdbl ? nvrd / 2 : nvrd;
                exp_addr = {first_addr[15:8], 8'(xi)};
                exp_sel  = hdbl ? nvrd[0] : 1'b0;
                exp_ph   = exp_sel ? 2'd3 : 2'd2;
                if (VADDR !== exp_addr) bad++;
                if (VSEL !== exp_sel) bad++;
                if (PH !== exp_ph) bad++;
                last_addr = VADDR;
                nvrd++;
            end
            prev_vrd = VRD;
        end
    endtask

    int          r_nvrd, r_npix, r_first_t, r_vact, r_bad;
    logic [15:0] r_first, r_last;

    task automatic run_line(input logic hdbl);
        start_line();
        capture(hdbl, r_nvrd, r_npix, r_first_t, r_vact, r_bad, r_first, r_last);
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        step(); step(); step();
        n_checks++; if (nAE !== 1'b1) begin n_fail++; $display("FAIL reset_nae: got %b expected 1", nAE); end
        n_checks++; if (VRD !== 1'b0) begin n_fail++; $display("FAIL reset_vrd: got %b expected 0", VRD); end
        n_checks++; if (VSEL !== 1'b0) begin n_fail++; $display("FAIL reset_vsel: got %b expected 0", VSEL); end
        n_checks++; if (VADDR !== 16'h0000) begin n_fail++; $display("FAIL reset_vaddr: got %h expected 0000", VADDR); end
        n_checks++; if (PIXLD !== 1'b0) begin n_fail++; $display("FAIL reset_pixld: got %b expected 0", PIXLD); end
        n_checks++; if (VACTIVE !== 1'b0) begin n_fail++; $display("FAIL reset_vactive: got %b expected 0", VACTIVE); end
        nRESET = 1'b1;
    endtask

    task automatic test_idle_slots();
        logic exp_nae;
        for (int i = 0; i < 64; i++) begin
            if (i == 20) begin
                OUTWR = 1'b1; OUTV = 2'b10;
            end
            step();
            exp_nae = !((PH == 2'd0) || (PH == 2'd1));
            n_checks++; if (nAE !== exp_nae) begin n_fail++; $display("FAIL idle_nae: PH=%0d got %b expected %b", PH, nAE, exp_nae); end
            n_checks++; if (VRD !== 1'b0) begin n_fail++; $display("FAIL idle_vrd: got %b expected 0", VRD); end
        end
        send_out(2'b11);
    endtask

    task automatic test_line_single();
        set_cfg(1'b1, 1'b0, 8'h08);
        send_out(2'b01);
        send_out(2'b11);
        run_line(1'b0);
        n_checks++; if (r_nvrd !== 160) begin n_fail++; $display("FAIL line_nvrd: got %0d expected 160", r_nvrd); end
        n_checks++; if (r_npix !== 160) begin n_fail++; $display("FAIL line_npixld: got %0d expected 160", r_npix); end
        n_checks++; if (r_first_t !== 46) begin n_fail++; $display("FAIL line_latency: got %0d expected 46", r_first_t); end
        n_checks++; if (r_first !== 16'h0800) begin n_fail++; $display("FAIL line_first_addr: got %h expected 0800", r_first); end
        n_checks++; if (r_last !== 16'h089F) begin n_fail++; $display("FAIL line_last_addr: got %h expected 089f", r_last); end
        n_checks++; if (r_vact !== 640) begin n_fail++; $display("FAIL line_vactive_ticks: got %0d expected 640", r_vact); end
        n_checks++; if (r_bad !== 0) begin n_fail++; $display("FAIL line_tick_errors: got %0d expected 0", r_bad); end
    endtask

    task automatic test_hdbl();
        set_cfg(1'b1, 1'b1, 8'h08);
        run_line(1'b1);
        n_checks++; if (r_nvrd !== 320) begin n_fail++; $display("FAIL hdbl_nvrd: got %0d expected 320", r_nvrd); end
        n_checks++; if (r_npix !== 320) begin n_fail++; $display("FAIL hdbl_npixld: got %0d expected 320", r_npix); end
        n_checks++; if (r_first_t !== 46) begin n_fail++; $display("FAIL hdbl_latency: got %0d expected 46", r_first_t); end
        n_checks++; if (r_first !== 16'h0800) begin n_fail++; $display("FAIL hdbl_first_addr: got %h expected 0800", r_first); end
        n_checks++; if (r_last !== 16'h089F) begin n_fail++; $display("FAIL hdbl_last_addr: got %h expected 089f", r_last); end
        n_checks++; if (r_vact !== 640) begin n_fail++; $display("FAIL hdbl_vactive_ticks: got %0d expected 640", r_vact); end
        n_checks++; if (r_bad !== 0) begin n_fail++; $display("FAIL hdbl_tick_errors: got %0d expected 0", r_bad); end
    endtask

    // Frame lines 2..24 (lines 0,1 were done above), with an abort on line 3.
    task automatic test_rows_abort_done();
        logic [7:0] exp_page;
        set_cfg(1'b1, 1'b0, 8'h08);
        run_line(1'b0);
        n_checks++; if (r_first !== 16'h0800) begin n_fail++; $display("FAIL line2_addr: got %h expected 0800", r_first); end
        // line 3 (rep 3): abort at x = 50
        start_line();
        repeat (246) step();
        n_checks++; if (VRD !== 1'b1) begin n_fail++; $display("FAIL abort_pre_vrd: got %b expected 1", VRD); end
        n_checks++; if (VADDR !== 16'h0832) begin n_fail++; $display("FAIL abort_pre_addr: got %h expected 0832", VADDR); end
        n_checks++; if (VACTIVE !== 1'b1) begin n_fail++; $display("FAIL abort_pre_vactive: got %b expected 1", VACTIVE); end
        send_out(2'b10);
        n_checks++; if (VACTIVE !== 1'b0) begin n_fail++; $display("FAIL abort_vactive: got %b expected 0", VACTIVE); end
        n_checks++; if (VRD !== 1'b0) begin n_fail++; $display("FAIL abort_vrd: got %b expected 0", VRD); end
        step(); step();
        run_line(1'b0);
        n_checks++; if (r_first !== 16'h0800) begin n_fail++; $display("FAIL abort_redo_addr: got %h expected 0800", r_first); end
        n_checks++; if (r_nvrd !== 160) begin n_fail++; $display("FAIL abort_redo_nvrd: got %0d expected 160", r_nvrd); end
        n_checks++; if (r_bad !== 0) begin n_fail++; $display("FAIL abort_redo_errors: got %0d expected 0", r_bad); end
        for (int l = 4; l < 24; l++) begin
            exp_page = 8'h08 + 8'(l / 4);
            run_line(1'b0);
            n_checks++; if (r_first !== {exp_page, 8'h00}) begin n_fail++; $display("FAIL row_page line %0d: got %h expected %h00", l, r_first, exp_page); end
            n_checks++; if (r_nvrd !== 160) begin n_fail++; $display("FAIL row_nvrd line %0d: got %0d expected 160", l, r_nvrd); end
        end
        run_line(1'b0);
        n_checks++; if (r_nvrd !== 0) begin n_fail++; $display("FAIL done_nvrd: got %0d expected 0", r_nvrd); end
        n_checks++; if (r_vact !== 0) begin n_fail++; $display("FAIL done_vactive: got %0d expected 0", r_vact); end
        send_out(2'b01);
        send_out(2'b11);
        run_line(1'b0);
        n_checks++; if (r_first !== 16'h0800) begin n_fail++; $display("FAIL vsync_restart_addr: got %h expected 0800", r_first); end
        n_checks++; if (r_nvrd !== 160) begin n_fail++; $display("FAIL vsync_restart_nvrd: got %0d expected 160", r_nvrd); end
    endtask

    task automatic test_wrap_and_reset();
        int k;
        int seen;
        set_cfg(1'b1, 1'b0, 8'hFF);
        send_out(2'b01);
        send_out(2'b11);
        for (int l = 0; l < 12; l++) begin
            run_line(1'b0);
            if (l == 0) begin
                n_checks++; if (r_first !== 16'hFF00) begin n_fail++; $display("FAIL wrap_row0: got %h expected ff00", r_first); end
            end
            if (l == 4) begin
                n_checks++; if (r_first !== 16'h0000) begin n_fail++; $display("FAIL wrap_row1: got %h expected 0000", r_first); end
            end
        end
        start_line();
        k = 0;
        while (VRD !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        n_checks++; if (VRD !== 1'b1) begin n_fail++; $display("FAIL wrap_vrd_timeout: got %b expected 1", VRD); end
        n_checks++; if (VADDR !== 16'h0200) begin n_fail++; $display("FAIL wrap_row3: got %h expected 0200", VADDR); end
        nRESET = 1'b0;
        #1;
        n_checks++; if (nAE !== 1'b1) begin n_fail++; $display("FAIL midreset_nae: got %b expected 1", nAE); end
        n_checks++; if (VRD !== 1'b0) begin n_fail++; $display("FAIL midreset_vrd: got %b expected 0", VRD); end
        n_checks++; if (VSEL !== 1'b0) begin n_fail++; $display("FAIL midreset_vsel: got %b expected 0", VSEL); end
        n_checks++; if (VADDR !== 16'h0000) begin n_fail++; $display("FAIL midreset_vaddr: got %h expected 0000", VADDR); end
        n_checks++; if (PIXLD !== 1'b0) begin n_fail++; $display("FAIL midreset_pixld: got %b expected 0", PIXLD); end
        n_checks++; if (VACTIVE !== 1'b0) begin n_fail++; $display("FAIL midreset_vactive: got %b expected 0", VACTIVE); end
        step(); step();
        n_checks++; if (nAE !== 1'b1) begin n_fail++; $display("FAIL held_reset_nae: got %b expected 1", nAE); end
        nRESET = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (VRD === 1'b1 || VACTIVE === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL post_reset_idle: got %0d fetch ticks expected 0", seen); end
    endtask

    initial begin
        #2;
        test_reset();
        test_idle_slots();
        test_line_single();
        test_hdbl();
        test_rows_abort_done();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
